// File: rtl/vga_timing_gen.sv
// 640x480 @ ~60 Hz VGA timing generator for a 50 MHz clock (2 clocks per pixel).
// Built from a shared wrap counter and half-open range checks on the registered counters.

module vga_wrap_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (en)
      cnt <= clr ? '0 : cnt + W'(1);
  end
endmodule

module vga_range_check #(
  parameter int W    = 11,
  parameter int LOW  = 0,
  parameter int HIGH = 1
) (
  input  logic [W-1:0] value,
  output logic         in_range
);
  // A zero lower bound would make the >= test constant, so drop it.
  if (LOW == 0) begin : g_upper_only
    assign in_range = (value < W'(HIGH));
  end else begin : g_both
    assign in_range = (value >= W'(LOW)) && (value < W'(HIGH));
  end
endmodule

module vga_timing_gen #(
  parameter int H_TOTAL  = 1600,
  parameter int H_SYNC   = 192,
  parameter int H_BP     = 96,
  parameter int H_ACTIVE = 1280,
  parameter int V_TOTAL  = 521,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int V_ACTIVE = 480
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  output logic       HS,
  output logic       VS,
  output logic       blank,
  output logic [9:0] row,
  output logic [9:0] col
);
  localparam int HW          = $clog2(H_TOTAL);
  localparam int VW          = $clog2(V_TOTAL);
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          h_sync_win;
  logic          v_sync_win;
  logic          h_act;
  logic          v_act;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  vga_wrap_counter #(.W(HW)) u_h_cnt (
    .clk   (CLOCK_50),
    .reset (reset),
    .en    (1'b1),
    .clr   (h_last),
    .cnt   (h_cnt)
  );

  // Lines advance only on the last clock of each line.
  vga_wrap_counter #(.W(VW)) u_v_cnt (
    .clk   (CLOCK_50),
    .reset (reset),
    .en    (h_last),
    .clr   (v_last),
    .cnt   (v_cnt)
  );

  vga_range_check #(.W(HW), .LOW(0), .HIGH(H_SYNC)) u_h_sync (
    .value    (h_cnt),
    .in_range (h_sync_win)
  );

  vga_range_check #(.W(VW), .LOW(0), .HIGH(V_SYNC)) u_v_sync (
    .value    (v_cnt),
    .in_range (v_sync_win)
  );

  vga_range_check #(.W(HW), .LOW(H_ACT_START), .HIGH(H_ACT_END)) u_h_act (
    .value    (h_cnt),
    .in_range (h_act)
  );

  vga_range_check #(.W(VW), .LOW(V_ACT_START), .HIGH(V_ACT_END)) u_v_act (
    .value    (v_cnt),
    .in_range (v_act)
  );

  assign HS    = ~h_sync_win;
  assign VS    = ~v_sync_win;
  assign blank = ~(h_act & v_act);
  // Halving the horizontal offset holds each col value for two clocks.
  assign col   = h_act ? 10'((h_cnt - HW'(H_ACT_START)) >> 1) : '0;
  assign row   = v_act ? 10'(v_cnt - VW'(V_ACT_START)) : '0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; late-frame points are reached by preloading the counters.
module tb_vga_timing_gen;
  logic       CLOCK_50;
  logic       reset;
  logic       HS;
  logic       VS;
  logic       blank;
  logic [9:0] row;
  logic [9:0] col;

  int n_vec;
  int n_err;
  int clk_idx;

  vga_timing_gen dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .HS       (HS),
    .VS       (VS),
    .blank    (blank),
    .row      (row),
    .col      (col)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s at clock %0d: observed %0d expected %0d", tag, clk_idx, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
    clk_idx += n;
  endtask

  task automatic adv_to(input int target);
    adv(target - clk_idx);
  endtask

  logic [10:0] h_load;
  logic [9:0]  v_load;

  task automatic jump(input int h, input int v);
    h_load = 11'(h);
    v_load = 10'(v);
    force dut.u_h_cnt.cnt = h_load;
    force dut.u_v_cnt.cnt = v_load;
    #1;
    release dut.u_h_cnt.cnt;
    release dut.u_v_cnt.cnt;
    clk_idx = v * 1600 + h;
  endtask

  task automatic chk_post_reset(input string tag);
    chk({tag, "_h_cnt"}, int'(dut.h_cnt), 0);
    chk({tag, "_v_cnt"}, int'(dut.v_cnt), 0);
    chk({tag, "_HS"},    int'(HS), 0);
    chk({tag, "_VS"},    int'(VS), 0);
    chk({tag, "_blank"}, int'(blank), 1);
    chk({tag, "_row"},   int'(row), 0);
    chk({tag, "_col"},   int'(col), 0);
  endtask

  initial begin
    int hs_low;
    int first_high;
    int vs_low;
    n_vec   = 0;
    n_err   = 0;
    clk_idx = 0;
    reset   = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    #1;
    reset   = 1'b0;
    clk_idx = 0;
    chk_post_reset("reset");

    // One full line of HS
    hs_low     = 0;
    first_high = -1;
    for (int i = 0; i < 1600; i++) begin
      if (HS === 1'b0) hs_low++;
      else if (first_high < 0) first_high = i;
      adv(1);
    end
    chk("hs_low_clocks", hs_low, 192);
    chk("hs_first_high", first_high, 192);
    chk("hs_next_fall", int'(HS), 0);
    chk("line1_v_cnt", int'(dut.v_cnt), 1);

    adv_to(3199);
    chk("vs_last_low", int'(VS), 0);
    adv(1);
    chk("vs_first_high", int'(VS), 1);
    chk("vs_high_v_cnt", int'(dut.v_cnt), 2);

    // First visible line
    adv_to(49887);
    chk("pre_first_blank", int'(blank), 1);
    adv(1);
    chk("first_px_blank", int'(blank), 0);
    chk("first_px_row", int'(row), 0);
    chk("first_px_col", int'(col), 0);
    adv(1);
    chk("first_px_hold_col", int'(col), 0);
    adv(1);
    chk("second_px_col", int'(col), 1);
    adv_to(51167);
    chk("line_end_col", int'(col), 639);
    chk("line_end_blank", int'(blank), 0);
    adv(1);
    chk("after_line_blank", int'(blank), 1);
    chk("after_line_col", int'(col), 0);
    adv_to(51488);
    chk("row1_blank", int'(blank), 0);
    chk("row1_row", int'(row), 1);
    chk("row1_col", int'(col), 0);

    // Last visible pixel
    jump(1566, 510);
    adv(1);
    chk("last_px_row", int'(row), 479);
    chk("last_px_col", int'(col), 639);
    chk("last_px_blank", int'(blank), 0);
    adv(1);
    chk("after_last_blank", int'(blank), 1);

    // Frame wrap and second frame VS
    jump(1598, 520);
    adv(1);
    chk("frame_end_VS", int'(VS), 1);
    chk("frame_end_HS", int'(HS), 1);
    adv(1);
    chk("wrap_h_cnt", int'(dut.h_cnt), 0);
    chk("wrap_v_cnt", int'(dut.v_cnt), 0);
    chk("wrap_VS", int'(VS), 0);
    chk("wrap_HS", int'(HS), 0);
    vs_low = 0;
    for (int i = 0; i < 3200; i++) begin
      if (VS === 1'b0) vs_low++;
      adv(1);
    end
    chk("frame2_vs_low_clocks", vs_low, 3200);
    chk("frame2_vs_high", int'(VS), 1);

    // Mid-frame reset at clock 400000
    jump(0, 250);
    chk("mid_v_cnt", int'(dut.v_cnt), 250);
    chk("mid_VS", int'(VS), 1);
    reset = 1'b1;
    adv(1);
    reset = 1'b0;
    clk_idx = 0;
    chk_post_reset("mid_reset");
    adv(191);
    chk("restart_hs_low", int'(HS), 0);
    adv(1);
    chk("restart_hs_high", int'(HS), 1);
    chk("restart_h_cnt", int'(dut.h_cnt), 192);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
